// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the 3x3 systolic matrix-multiply sequencer:
//   - default matrix dimension and element widths
//   - sequencer FSM state encoding
//   - packing helpers that locate an element inside a flattened matrix bus
// -----------------------------------------------------------------------------
package matmul_pkg;

    localparam int MM_N     = 3;             // matrix dimension (N x N array)
    localparam int MM_DW    = 8;             // operand element width
    localparam int MM_CW    = 16;            // accumulator / result element width
    localparam int MM_DRAIN = 2 * MM_N - 1;  // zero-feed cycles before capture

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } seq_state_e;

    // Bit offset of operand element [row][col] in an N*N*DW packed bus
    // (row-major). Used for both A[i][k] and B[k][j].
    function automatic int idx_a(input int row, input int col);
        return (row * MM_N + col) * MM_DW;
    endfunction

    // Bit offset of result element C[i][j] in an N*N*CW packed bus.
    function automatic int idx_c(input int row, input int col);
        return (row * MM_N + col) * MM_CW;
    endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
// Upstream feeder and result capture for an N x N systolic MAC array.
// Accepts one A/B operand pair, clears the array, streams column k of A and
// row k of B onto the array edges for k = 0..N-1 (the array skews internally),
// feeds zeros while the pipeline drains, then captures the packed C result and
// holds it behind a valid/ready handshake. Only one job is in flight at a time.
//
// Ports
//   clk, rst    clock (rising edge), synchronous active-high reset
//   in_valid    operand pair valid          in_ready   high only in IDLE
//   a_mat       A[i][k] at [(i*N+k)*DW +: DW]
//   b_mat       B[k][j] at [(k*N+j)*DW +: DW]
//   arr_rst_n   active-low array clear; low during rst and in CLEAR
//   a_edge      row i operand at [i*DW +: DW]   (zero outside STREAM)
//   b_edge      col j operand at [j*DW +: DW]   (zero outside STREAM)
//   c_arr       live array accumulators, C[i][j] at [(i*N+j)*CW +: CW]
//   out_valid   result valid, held until out_ready
//   out_ready   consumer ready
//   c_out       captured result, same packing as c_arr
//   busy        high in every state except IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N     = MM_N,
    parameter int DW    = MM_DW,
    parameter int CW    = MM_CW,
    parameter int DRAIN = 2 * N - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*N*DW-1:0]   a_mat,
    input  logic [N*N*DW-1:0]   b_mat,
    output logic                arr_rst_n,
    output logic [N*DW-1:0]     a_edge,
    output logic [N*DW-1:0]     b_edge,
    input  logic [N*N*CW-1:0]   c_arr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*CW-1:0]   c_out,
    output logic                busy
);

    // One counter serves both the STREAM column index and the DRAIN count.
    localparam int CNT_MAX = (N > DRAIN) ? N : DRAIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] K_LAST     = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N*N*DW-1:0]      a_op_q, a_op_d;
    logic [N*N*DW-1:0]      b_op_q, b_op_d;
    logic [N*DW-1:0]        a_edge_q, a_edge_d;
    logic [N*DW-1:0]        b_edge_q, b_edge_d;
    logic [N*N*CW-1:0]      c_out_q;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   arr_rst_n_q;

    // FSM next state, counter and operand latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_op_d  = a_op_q;
        b_op_d  = b_op_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_op_d  = a_mat;
                    b_op_d  = b_mat;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                cnt_d   = CNT_W'(0);
            end
            S_STREAM: begin
                if (cnt_q == K_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    // Edge operands for the upcoming cycle: column k of A / row k of B while
    // streaming, zero otherwise. Exactly one k matches, so OR-merging selects it.
    always_comb begin
        a_edge_d = '0;
        b_edge_d = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                a_edge_d[r*DW +: DW] = a_edge_d[r*DW +: DW] |
                    (((state_d == S_STREAM) && (cnt_d == CNT_W'(k)))
                        ? a_op_q[(r*N + k)*DW +: DW] : {DW{1'b0}});
                b_edge_d[r*DW +: DW] = b_edge_d[r*DW +: DW] |
                    (((state_d == S_STREAM) && (cnt_d == CNT_W'(k)))
                        ? b_op_q[(k*N + r)*DW +: DW] : {DW{1'b0}});
            end
        end
    end

    // State, operand and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_W'(0);
            a_op_q      <= '0;
            b_op_q      <= '0;
            a_edge_q    <= '0;
            b_edge_q    <= '0;
            c_out_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            arr_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_op_q      <= a_op_d;
            b_op_q      <= b_op_d;
            a_edge_q    <= a_edge_d;
            b_edge_q    <= b_edge_d;
            out_valid_q <= (state_d == S_HOLD);
            in_ready_q  <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            arr_rst_n_q <= (state_d != S_CLEAR);
            // Accumulators are final by the CAPTURE cycle; c_out is a raw copy.
            if (state_q == S_CAPTURE) begin
                c_out_q <= c_arr;
            end else begin
                c_out_q <= c_out_q;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign arr_rst_n = arr_rst_n_q;
    assign a_edge    = a_edge_q;
    assign b_edge    = b_edge_q;
    assign out_valid = out_valid_q;
    assign c_out     = c_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
// Drives matmul_sequencer connected to a behavioural N x N systolic MAC array
// (row i of A delayed i cycles, column j of B delayed j cycles, operands passed
// right/down through PE registers, accumulators cleared by arr_rst_n low).
// Expected results come from a plain matrix-multiply model and are queued at
// the accept edge, then popped when out_valid is observed.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int N   = MM_N;
    localparam int DW  = MM_DW;
    localparam int CW  = MM_CW;
    localparam int AW  = N * N * DW;
    localparam int EW  = N * DW;
    localparam int CAW = N * N * CW;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   a_mat;
    logic [AW-1:0]   b_mat;
    logic            arr_rst_n;
    logic [EW-1:0]   a_edge;
    logic [EW-1:0]   b_edge;
    logic [CAW-1:0]  c_arr;
    logic            out_valid;
    logic            out_ready;
    logic [CAW-1:0]  c_out;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [CAW-1:0] exp_q [$];

    matmul_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .arr_rst_n (arr_rst_n),
        .a_edge    (a_edge),
        .b_edge    (b_edge),
        .c_arr     (c_arr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural systolic array ----------------
    logic [DW-1:0] a_sk   [N][N];
    logic [DW-1:0] b_sk   [N][N];
    logic [DW-1:0] a_row  [N];
    logic [DW-1:0] b_col  [N];
    logic [DW-1:0] a_in   [N][N];
    logic [DW-1:0] b_in   [N][N];
    logic [DW-1:0] a_pipe [N][N];
    logic [DW-1:0] b_pipe [N][N];
    logic [CW-1:0] acc    [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (i == 0) begin
                a_row[i] = a_edge[0 +: DW];
                b_col[i] = b_edge[0 +: DW];
            end else begin
                a_row[i] = a_sk[i][i-1];
                b_col[i] = b_sk[i][i-1];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) a_in[i][j] = a_row[i];
                else        a_in[i][j] = a_pipe[i][j-1];
                if (i == 0) b_in[i][j] = b_col[j];
                else        b_in[i][j] = b_pipe[i-1][j];
            end
        end
        c_arr = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_arr[idx_c(i, j) +: CW] = acc[i][j];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < N; d++) begin
                if (!arr_rst_n) begin
                    a_sk[i][d] <= '0;
                    b_sk[i][d] <= '0;
                end else if (d == 0) begin
                    a_sk[i][d] <= a_edge[i*DW +: DW];
                    b_sk[i][d] <= b_edge[i*DW +: DW];
                end else begin
                    a_sk[i][d] <= a_sk[i][d-1];
                    b_sk[i][d] <= b_sk[i][d-1];
                end
            end
            for (int j = 0; j < N; j++) begin
                if (!arr_rst_n) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end else begin
                    a_pipe[i][j] <= a_in[i][j];
                    b_pipe[i][j] <= b_in[i][j];
                    acc[i][j]    <= acc[i][j] + CW'(a_in[i][j]) * CW'(b_in[i][j]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [CAW-1:0] golden(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [CAW-1:0] c;
        logic [CW-1:0]  s;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + CW'(a[idx_a(i, k) +: DW]) * CW'(b[idx_a(k, j) +: DW]);
                c[idx_c(i, j) +: CW] = s;
            end
        end
        return c;
    endfunction

    // Row-major matrix with element e = start + step*e
    function automatic logic [AW-1:0] mat_seq(input int start, input int step);
        logic [AW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'(start + step*e);
        return m;
    endfunction

    function automatic logic [AW-1:0] mat_ident();
        logic [AW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[idx_a(i, i) +: DW] = 8'd1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [CAW-1:0] obs, input logic [CAW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one job; hold>0 keeps out_ready low that many cycles (pulsing
    // in_valid midway), ready_early=1 keeps out_ready high from the start.
    task automatic run_job(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input int hold, input bit ready_early, output logic [CAW-1:0] got);
        int lat;
        logic [CAW-1:0] held;
        logic [CAW-1:0] exp_c;
        out_ready = ready_early;
        lat = 0;
        while (in_ready !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        chk({tag, "_in_ready_idle"}, CAW'(in_ready), CAW'(1));
        a_mat = a; b_mat = b; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(golden(a, b));
        @(negedge clk);
        in_valid = 1'b0; a_mat = '0; b_mat = '0;
        chk({tag, "_busy_after_accept"}, CAW'(busy), CAW'(1));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk({tag, "_latency"}, CAW'(lat), CAW'(10));
        got = c_out;
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, CAW'(0), CAW'(1));
        end else begin
            exp_c = exp_q.pop_front();
            chk({tag, "_c_out"}, c_out, exp_c);
        end
        held = c_out;
        for (int h = 0; h < hold; h++) begin
            if (h == 5) begin
                in_valid = 1'b1; a_mat = mat_seq(3, 1); b_mat = mat_seq(7, 2);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_hold_valid"}, CAW'(out_valid), CAW'(1));
            chk({tag, "_hold_c_out"}, c_out, held);
            chk({tag, "_hold_in_ready"}, CAW'(in_ready), CAW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_dropped"}, CAW'(out_valid), CAW'(0));
        chk({tag, "_idle_after"}, CAW'(busy), CAW'(0));
        chk({tag, "_in_ready_after"}, CAW'(in_ready), CAW'(1));
    endtask

    // ---------------- directed sequence ----------------
    logic [CAW-1:0] got;
    logic [CAW-1:0] exp_c;
    int vcount;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_mat = '0; b_mat = '0;
        repeat (3) @(negedge clk);
        chk("rst_arr_rst_n", CAW'(arr_rst_n), CAW'(0));
        chk("rst_out_valid", CAW'(out_valid), CAW'(0));
        chk("rst_c_out", c_out, CAW'(0));
        chk("rst_edges", CAW'({a_edge, b_edge}), CAW'(0));
        chk("rst_busy", CAW'(busy), CAW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_arr_rst_n", CAW'(arr_rst_n), CAW'(1));
        chk("rst_release_in_ready", CAW'(in_ready), CAW'(1));

        // out_ready high while idle has no effect; then A=I, B=[1..9]
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready_no_valid", CAW'(out_valid), CAW'(0));
        run_job("ident", mat_ident(), mat_seq(1, 1), 0, 1'b0, got);
        for (int e = 0; e < N*N; e++) exp_c[e*CW +: CW] = CW'(e + 1);
        chk("ident_const", got, exp_c);

        // A=[1..9], B=[9..1]
        run_job("seq", mat_seq(1, 1), mat_seq(9, -1), 0, 1'b0, got);
        chk("seq_row0", CAW'(got[0 +: 3*CW]), CAW'({16'd18, 16'd24, 16'd30}));

        // all 255 -> wraps, with a 20-cycle stall and an ignored in_valid pulse
        run_job("wrap", {AW{1'b1}}, {AW{1'b1}}, 20, 1'b0, got);
        chk("wrap_const", got, {(N*N){16'd64003}});
        repeat (3) @(negedge clk);
        chk("pulse_not_accepted", CAW'(busy), CAW'(0));

        // back-to-back: A=I, B=0 straight after the wrap job
        run_job("b2b", mat_ident(), '0, 0, 1'b1, got);
        chk("b2b_zero", got, CAW'(0));

        // reset mid-stream at k=1
        a_mat = mat_seq(1, 1); b_mat = mat_ident(); in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(golden(a_mat, b_mat));
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_k0_a", CAW'(a_edge), CAW'({8'd7, 8'd4, 8'd1}));
        chk("stream_k0_b", CAW'(b_edge), CAW'({8'd0, 8'd0, 8'd1}));
        @(negedge clk);
        chk("stream_k1_a", CAW'(a_edge), CAW'({8'd8, 8'd5, 8'd2}));
        chk("stream_k1_b", CAW'(b_edge), CAW'({8'd0, 8'd1, 8'd0}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("abort_busy", CAW'(busy), CAW'(0));
        chk("abort_edges", CAW'({a_edge, b_edge}), CAW'(0));
        chk("abort_out_valid", CAW'(out_valid), CAW'(0));
        chk("abort_arr_rst_n", CAW'(arr_rst_n), CAW'(0));
        @(negedge clk);
        chk("abort_arr_rst_n_back", CAW'(arr_rst_n), CAW'(1));
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) vcount++;
        end
        chk("abort_no_result", CAW'(vcount), CAW'(0));

        // fresh job after abort
        run_job("fresh", mat_seq(2, 3), mat_seq(5, 7), 0, 1'b0, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
